program_memory: RTL

Parametrised, loadable instruction store for the 8-bit processor. It replaces the fixed, file-initialised instruction table with RAM that is written at run time through a streaming load port. Instructions are served through a valid/ready fetch port with a one-deep registered output and an out-of-range fault flag. It sits between the fetch stage (PC source) and the decoder.

---
 rtl/program_memory_pkg.sv | 15 +
 rtl/program_memory_array.sv | 28 ++
 rtl/program_memory.sv | 127 ++++++++++++
 3 files changed

// File: rtl/program_memory_pkg.sv
// Shared types and default parameters for the loadable program memory.
package program_memory_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } pm_state_e;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 25;
  localparam logic [DATA_W-1:0] FILL = 8'h00;

endpackage

// File: rtl/program_memory_array.sv
// Instruction storage: one synchronous write port, one combinational read port, no reset.
module program_memory_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 25
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Addresses beyond DEPTH are dropped on write and read as zero.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DEPTH_C))
      mem_q[waddr[IW-1:0]] <= wdata;
  end

  assign rdata = ({1'b0, raddr} < DEPTH_C) ? mem_q[raddr[IW-1:0]] : '0;

endmodule

// File: rtl/program_memory.sv
// Loadable instruction store: streaming load port, valid/ready fetch port with a
// one-deep registered response and an out-of-range fault flag.
module program_memory #(
  parameter int DATA_W = program_memory_pkg::DATA_W,
  parameter int ADDR_W = program_memory_pkg::ADDR_W,
  parameter int DEPTH  = program_memory_pkg::DEPTH,
  parameter logic [DATA_W-1:0] FILL = program_memory_pkg::FILL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              load_overflow,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic              instr_fault,
  input  logic              instr_ready,
  output logic              running
);

  import program_memory_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  pm_state_e         state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              fault_q, fault_d;

  logic              load_acc, fetch_acc, full, addr_fault, we;
  logic [DATA_W-1:0] rdata;

  assign load_ready  = (state_q == LOAD) && !load_start;
  assign fetch_ready = (state_q == RUN) && !load_start && (!valid_q || instr_ready);
  assign load_acc    = load_valid && load_ready;
  assign fetch_acc   = fetch_valid && fetch_ready;
  assign full        = (count_q == DEPTH_C);
  assign addr_fault  = ({1'b0, fetch_addr} >= count_q);

  program_memory_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (count_q[ADDR_W-1:0]),
    .wdata (load_data),
    .raddr (fetch_addr),
    .rdata (rdata)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    instr_d = instr_q;
    fault_d = fault_q;
    we      = 1'b0;

    case (state_q)
      EMPTY:   if (load_start) state_d = LOAD;
      LOAD:    if (!load_start && load_acc && load_last) state_d = RUN;
      RUN:     if (load_start) state_d = LOAD;
      default: state_d = EMPTY;
    endcase

    if (load_start) begin
      count_d = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      // A word offered when full is dropped but still counts as accepted.
      if (load_acc) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we      = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      if (fetch_acc) begin
        valid_d = 1'b1;
        instr_d = addr_fault ? FILL : rdata;
        fault_d = addr_fault;
      end else if (valid_q && instr_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  assign load_count    = count_q;
  assign load_overflow = ovf_q;
  assign instr_valid   = valid_q;
  assign instr         = instr_q;
  assign instr_fault   = fault_q;
  assign running       = (state_q == RUN);

endmodule
